// File: rtl/io_clk_fifo_port.sv
// io_clk_fifo_port: GPIO strobe FIFO bridge between the processor and the core, with optional drop counter under IO_DROP_CNT_EN
module io_clk_fifo_port #(
  parameter int DATA_W = 16,
  parameter int IN_DEPTH = 16,
  parameter int OUT_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              io_clk,
  input  logic              wr_in,
  input  logic              rd_in,
  input  logic              newline,
  input  logic [DATA_W-1:0] bufferInput,
  output logic [DATA_W-1:0] bufferOut,
  output logic              FULL_in,
  output logic              EMPTY_in,
  output logic              FULL_out,
  output logic              EMPTY_out,
  output logic [DATA_W-1:0] core_data,
  output logic              core_newline,
  output logic              core_valid,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready
`ifdef IO_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int SW = DATA_W + 4;
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic s_clk, s_wr, s_rd, s_nl;
  logic [DATA_W-1:0] s_data;
  logic prev_q, edge_q, op_wr, op_rd, op_nl;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W:0] in_mem [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [IAW:0] in_wp, in_rp, in_wp_n, in_rp_n;
  logic [OAW:0] out_wp, out_rp, out_wp_n, out_rp_n;
  logic in_push, in_pop, out_push, out_pop;
  assign {s_clk, s_wr, s_rd, s_nl, s_data} = sync_q[SYNC_STAGES-1];
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      {op_wr, op_rd, op_nl, op_data} <= '0;
    end else begin
      sync_q[0] <= {io_clk, wr_in, rd_in, newline, bufferInput};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s_clk;
      edge_q <= s_clk & ~prev_q;
      {op_wr, op_rd, op_nl, op_data} <= {s_wr, s_rd, s_nl, s_data};
    end
  end
  assign in_push = edge_q & op_wr & ~FULL_in;
  assign in_pop = core_valid & core_ready;
  assign core_valid = ~EMPTY_in;
  assign {core_newline, core_data} = in_mem[in_rp[IAW-1:0]];
  assign in_wp_n = in_wp + (IAW+1)'(in_push);
  assign in_rp_n = in_rp + (IAW+1)'(in_pop);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_wp <= '0;
      in_rp <= '0;
      EMPTY_in <= 1'b1;
      FULL_in <= 1'b0;
    end else begin
      in_wp <= in_wp_n;
      in_rp <= in_rp_n;
      EMPTY_in <= in_wp_n == in_rp_n;
      FULL_in <= (in_wp_n[IAW] != in_rp_n[IAW]) && (in_wp_n[IAW-1:0] == in_rp_n[IAW-1:0]);
    end
  end
  always_ff @(posedge Clk) if (in_push) in_mem[in_wp[IAW-1:0]] <= {op_nl, op_data};
  assign res_ready = ~FULL_out;
  assign out_push = res_valid & res_ready;
  assign out_pop = edge_q & op_rd & ~EMPTY_out;
  assign out_wp_n = out_wp + (OAW+1)'(out_push);
  assign out_rp_n = out_rp + (OAW+1)'(out_pop);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_wp <= '0;
      out_rp <= '0;
      EMPTY_out <= 1'b1;
      FULL_out <= 1'b0;
    end else begin
      out_wp <= out_wp_n;
      out_rp <= out_rp_n;
      EMPTY_out <= out_wp_n == out_rp_n;
      FULL_out <= (out_wp_n[OAW] != out_rp_n[OAW]) && (out_wp_n[OAW-1:0] == out_rp_n[OAW-1:0]);
    end
  end
  always_ff @(posedge Clk) if (out_push) out_mem[out_wp[OAW-1:0]] <= res_data;
  always_ff @(posedge Clk) begin
    if (Rst) bufferOut <= '0;
    else if (out_rp_n != out_wp_n) bufferOut <= (out_rp_n == out_wp) ? res_data : out_mem[out_rp_n[OAW-1:0]];
  end
`ifdef IO_DROP_CNT_EN
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + 9'(edge_q & op_wr & FULL_in) + 9'(edge_q & op_rd & EMPTY_out);
  always_ff @(posedge Clk) drop_cnt <= Rst ? 8'd0 : (drop_sum[8] ? 8'hff : drop_sum[7:0]);
`endif
endmodule

// File: tb/tb_io_clk_fifo_port.sv
// tb_io_clk_fifo_port: randomized queue-model bench for io_clk_fifo_port
module tb_io_clk_fifo_port;
  logic clk = 0, rst = 1, io_clk = 0, wr_in = 0, rd_in = 0, newline = 0;
  logic [15:0] buffer_input = 0, buffer_out, core_data, res_data = 0;
  logic full_in, empty_in, full_out, empty_out, core_newline, core_valid, core_ready = 0, res_valid = 0, res_ready;
`ifdef IO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int n_cmp = 0, n_err = 0, drops = 0;
  logic [16:0] in_q [$];
  logic [15:0] out_q [$];
  io_clk_fifo_port dut (
    .Clk(clk), .Rst(rst), .io_clk(io_clk), .wr_in(wr_in), .rd_in(rd_in), .newline(newline),
    .bufferInput(buffer_input), .bufferOut(buffer_out),
    .FULL_in(full_in), .EMPTY_in(empty_in), .FULL_out(full_out), .EMPTY_out(empty_out),
    .core_data(core_data), .core_newline(core_newline), .core_valid(core_valid), .core_ready(core_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
`ifdef IO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, ".empty_in"}, 32'(empty_in), 32'(in_q.size() == 0));
    check({tag, ".full_in"}, 32'(full_in), 32'(in_q.size() == 16));
    check({tag, ".core_valid"}, 32'(core_valid), 32'(in_q.size() != 0));
    if (in_q.size() != 0) check({tag, ".core_head"}, 32'({core_newline, core_data}), 32'(in_q[0]));
    check({tag, ".empty_out"}, 32'(empty_out), 32'(out_q.size() == 0));
    check({tag, ".full_out"}, 32'(full_out), 32'(out_q.size() == 16));
    check({tag, ".res_ready"}, 32'(res_ready), 32'(out_q.size() != 16));
    if (out_q.size() != 0) check({tag, ".buffer_out"}, 32'(buffer_out), 32'(out_q[0]));
`ifdef IO_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drops > 255 ? 255 : drops));
`endif
  endtask
  task automatic model_gpio(input bit w, input bit r, input bit nl, input logic [15:0] d);
    if (r) begin
      if (out_q.size() != 0) void'(out_q.pop_front());
      else drops++;
    end
    if (w) begin
      if (in_q.size() < 16) in_q.push_back({nl, d});
      else drops++;
    end
  endtask
  task automatic strobe(input bit w, input bit r, input bit nl, input logic [15:0] d, input int hold);
    @(negedge clk);
    wr_in = w; rd_in = r; newline = nl; buffer_input = d;
    @(negedge clk);
    io_clk = 1;
    repeat (hold) @(negedge clk);
    io_clk = 0;
    repeat (5) @(negedge clk);
    wr_in = 0; rd_in = 0; newline = 0;
    model_gpio(w, r, nl, d);
  endtask
  task automatic core_take();
    @(negedge clk);
    core_ready = 1;
    @(negedge clk);
    core_ready = 0;
    if (in_q.size() != 0) void'(in_q.pop_front());
  endtask
  task automatic core_give(input logic [15:0] d);
    @(negedge clk);
    res_valid = 1; res_data = d;
    @(negedge clk);
    res_valid = 0;
    if (out_q.size() < 16) out_q.push_back(d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    in_q.delete(); out_q.delete(); drops = 0;
  endtask
  initial begin
    int bias;
    repeat (3) @(negedge clk);
    rst = 0;
    in_q.delete(); out_q.delete();
    check("reset.buffer_out", 32'(buffer_out), 32'h0);
    check_state("reset");
    @(negedge clk);
    wr_in = 1; buffer_input = 16'h0001;
    @(negedge clk);
    io_clk = 1;
    repeat (3) @(negedge clk);
    check("lat.early_valid", 32'(core_valid), 32'h0);
    @(negedge clk);
    check("lat.valid", 32'(core_valid), 32'h1);
    check("lat.data", 32'(core_data), 32'h0001);
    repeat (4) @(negedge clk);
    io_clk = 0;
    repeat (5) @(negedge clk);
    wr_in = 0;
    model_gpio(1, 0, 0, 16'h0001);
    strobe(1, 0, 0, 16'h0002, 6);
    strobe(1, 0, 1, 16'h0003, 6);
    check_state("push3");
    for (int i = 0; i < 3; i++) begin
      check_state("drain");
      core_take();
    end
    check_state("push_done");
    for (int i = 0; i < 17; i++) begin
      strobe(1, 0, 1'($urandom), 16'($urandom), 4);
      check_state(i == 15 ? "full16" : "fill");
    end
    for (int i = 0; i < 16; i++) core_take();
    check_state("full_drain");
    core_give(16'hAAAA);
    core_give(16'hBBBB);
    check_state("read.give");
    strobe(0, 1, 0, 16'h0, 5);
    check_state("read.pop1");
    strobe(0, 1, 0, 16'h0, 5);
    check_state("read.pop2");
    strobe(0, 1, 0, 16'h0, 5);
    check_state("read.ignored");
    core_give(16'h1234);
    strobe(1, 1, 0, 16'h5678, 20);
    check_state("simul_held");
    core_take();
    for (int i = 0; i < 8; i++) begin
      strobe(1, 0, 0, 16'($urandom), 4);
      core_give(16'($urandom));
    end
    check_state("half");
    do_reset();
    check("midrst.buffer_out", 32'(buffer_out), 32'h0);
    check_state("midrst");
    strobe(1, 0, 0, 16'hC0DE, 4);
    check_state("post_rst");
    core_take();
    bias = 0;
    for (int n = 0; n < 400; n++) begin
      int op;
      if (n % 50 == 0) bias = $urandom_range(0, 2);
      op = $urandom_range(0, 9);
      if (op < 4 + bias) begin
        logic [1:0] wr;
        wr = 2'($urandom);
        strobe(wr[0], wr[1], 1'($urandom), 16'($urandom), $urandom_range(4, 12));
      end else if (op < 7) core_take();
      else core_give(16'($urandom));
      check_state("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
